// File: rtl/bcd_8421_conv_if.sv
// Bus between a numeric data source and the binary-to-BCD converter.
// The data source drives the binary value; the converter returns six BCD digits.
interface bcd_8421_conv_if;
    logic [19:0] data;
    logic [3:0]  unit;
    logic [3:0]  ten;
    logic [3:0]  hun;
    logic [3:0]  tho;
    logic [3:0]  t_tho;
    logic [3:0]  h_hun;

    // Data source side: drives the value, observes the digits.
    modport master (
        output data,
        input  unit, ten, hun, tho, t_tho, h_hun
    );

    // Converter side: samples the value, drives the digits.
    modport slave (
        input  data,
        output unit, ten, hun, tho, t_tho, h_hun
    );
endinterface

// File: rtl/bcd_8421_conv.sv
// Free-running 20-bit binary to 6-digit BCD (8421) converter using the
// shift-and-add-3 method. Each conversion takes 22 steps of two clocks
// (adjust phase, then shift phase); the digit outputs are registered and
// only change at the end of a conversion, so partial results never show.
module bcd_8421_conv (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    bcd_8421_conv_if.slave   bus
);

    localparam logic [4:0] LOAD_STEP  = 5'd0;
    localparam logic [4:0] LAST_SHIFT = 5'd20;
    localparam logic [4:0] LAST_STEP  = 5'd21;

    // Working register: {BCD field h_hun..unit, binary field}.
    logic        phase_q, phase_d;
    logic [4:0]  cnt_shift_q, cnt_shift_d;
    logic [43:0] work_q, work_d;
    logic [23:0] bcd_q, bcd_d;

    // One BCD nibble correction: values 5..15 get +3 so the next doubling
    // carries into the neighbouring decade.
    function automatic logic [3:0] adjust_nibble(input logic [3:0] nib);
        logic [3:0] res;
        if (nib > 4'd4) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Apply the nibble correction to all six decades independently.
    function automatic logic [23:0] adjust_field(input logic [23:0] field);
        logic [23:0] res;
        res = 24'd0;
        for (int i = 0; i < 6; i++) begin
            res[i*4 +: 4] = adjust_nibble(field[i*4 +: 4]);
        end
        return res;
    endfunction

    // Next-state logic for the phase flag, step counter, working register and digits.
    always_comb begin
        phase_d     = ~phase_q;
        cnt_shift_d = cnt_shift_q;
        work_d      = work_q;
        bcd_d       = bcd_q;

        // Step counter advances after each shift phase; any out-of-range
        // value (never reached in normal operation) falls back to step 0.
        if (phase_q) begin
            if (cnt_shift_q >= LAST_STEP) begin
                cnt_shift_d = LOAD_STEP;
            end else begin
                cnt_shift_d = cnt_shift_q + 5'd1;
            end
        end else begin
            cnt_shift_d = cnt_shift_q;
        end

        if (cnt_shift_q == LOAD_STEP) begin
            // Only point where the input is sampled.
            if (phase_q) begin
                work_d = {24'd0, bus.data};
            end else begin
                work_d = work_q;
            end
        end else if (cnt_shift_q <= LAST_SHIFT) begin
            // Adjust then shift; the top bit shifted out is dropped, which
            // makes values above 999,999 wrap modulo 10^6.
            if (phase_q) begin
                work_d = {work_q[42:0], 1'b0};
            end else begin
                work_d = {adjust_field(work_q[43:20]), work_q[19:0]};
            end
        end else begin
            // Final step: publish all six digits together.
            if (phase_q && (cnt_shift_q == LAST_STEP)) begin
                bcd_d = work_q[43:20];
            end else begin
                bcd_d = bcd_q;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q     <= 1'b0;
            cnt_shift_q <= 5'd0;
            work_q      <= 44'd0;
            bcd_q       <= 24'd0;
        end else begin
            phase_q     <= phase_d;
            cnt_shift_q <= cnt_shift_d;
            work_q      <= work_d;
            bcd_q       <= bcd_d;
        end
    end

    assign bus.h_hun = bcd_q[23:20];
    assign bus.t_tho = bcd_q[19:16];
    assign bus.hun   = bcd_q[15:12];
    assign bus.tho   = bcd_q[11:8];
    assign bus.ten   = bcd_q[7:4];
    assign bus.unit  = bcd_q[3:0];

endmodule

// File: tb/tb_bcd_8421_conv.sv
// Scoreboard bench for the binary-to-BCD converter. Stimulus pushes the
// expected digits (from a decimal arithmetic reference) with a deadline;
// a negedge monitor pops and compares, and also checks that every output
// change is a whole, legal conversion landing on a 44-clock boundary.
module tb_bcd_8421_conv;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    bcd_8421_conv_if bus_if ();

    bcd_8421_conv dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_if)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        logic [23:0] exp;
        int          deadline;
        int          value;
    } exp_t;

    exp_t exp_q[$];
    bit   legal[int];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference: decimal digits of (v mod 10^6), least significant in [3:0].
    function automatic logic [23:0] ref_bcd(input int v);
        logic [23:0] r;
        int m;
        r = 24'd0;
        m = v % 1000000;
        for (int k = 0; k < 6; k++) begin
            r[k*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] out_vec();
        return {bus_if.h_hun, bus_if.t_tho, bus_if.hun,
                bus_if.tho, bus_if.ten, bus_if.unit};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Apply a settled value and expect it on the outputs within 'bound' clocks.
    task automatic issue(input int v, input int hold, input int bound);
        bus_if.data = 20'(v);
        legal[v % 1000000] = 1'b1;
        exp_q.push_back(exp_t'{ref_bcd(v), cyc + bound, v});
        repeat (hold) @(negedge sys_clk);
    endtask

    // Apply a short-lived value; it may or may not get converted.
    task automatic glitch(input int v, input int hold);
        bus_if.data = 20'(v);
        legal[v % 1000000] = 1'b1;
        repeat (hold) @(negedge sys_clk);
    endtask

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
        end
    end

    // Monitor: output-change sanity and scoreboard pops.
    initial begin
        logic [23:0] prev_out;
        logic [23:0] cur;
        int          last_chg;
        int          dec;
        bit          range_ok;
        prev_out = 24'd0;
        last_chg = -1;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                prev_out = 24'd0;
                last_chg = -1;
            end else begin
                cur = out_vec();
                if (cur != prev_out) begin
                    range_ok = 1'b1;
                    dec = 0;
                    for (int k = 5; k >= 0; k--) begin
                        if (cur[k*4 +: 4] > 4'd9) range_ok = 1'b0;
                        dec = dec * 10 + int'(cur[k*4 +: 4]);
                    end
                    tests++;
                    if (!range_ok) begin
                        fails++;
                        $display("FAIL digit_range: got %h, required every digit 0..9", cur);
                    end
                    tests++;
                    if (!range_ok || !legal.exists(dec)) begin
                        fails++;
                        $display("FAIL legal_value: got %h, required a value that was on data", cur);
                    end
                    if (last_chg >= 0) begin
                        tests++;
                        if (((cyc - last_chg) % 44) != 0) begin
                            fails++;
                            $display("FAIL update_spacing: got %0d clocks since last update, required a multiple of 44",
                                     cyc - last_chg);
                        end
                    end
                    last_chg = cyc;
                    prev_out = cur;
                end
                if (exp_q.size() > 0) begin
                    if (cur == exp_q[0].exp) begin
                        tests++;
                        void'(exp_q.pop_front());
                    end else if (cyc > exp_q[0].deadline) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard: data=%0d got %h, required %h by cycle %0d",
                                 exp_q[0].value, cur, exp_q[0].exp, exp_q[0].deadline);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int v;
        int wait_cnt;
        bus_if.data = 20'd0;
        legal[0]    = 1'b1;

        // Reset state with data = 0, then stays 0 after release.
        #30;
        check("reset_zero", out_vec(), 24'd0);
        #5 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        issue(0, 100, 88);
        check("hold_zero", out_vec(), 24'd0);

        // Directed decimal patterns, each held 3 us.
        issue(123456, 150, 88);
        check("direct_123456", out_vec(), 24'h123456);
        issue(654321, 150, 88);
        issue(987654, 150, 88);
        issue(999999, 150, 88);
        check("direct_999999", out_vec(), 24'h999999);

        // Mid-conversion toggling, then settle at 42.
        for (int i = 0; i < 5; i++) begin
            glitch(int'($urandom_range(0, 999999)), 3);
        end
        issue(42, 150, 88);
        check("settled_42", out_vec(), 24'h000042);

        // Beyond 999,999 the result wraps modulo 10^6.
        issue(1048575, 150, 88);
        check("wrap_1048575", out_vec(), 24'h048575);
        issue(1000000, 150, 88);

        // Random values across the full 20-bit range.
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 1048575));
            issue(v, 100, 88);
        end

        // Asynchronous reset between clock edges, mid-conversion.
        issue(777777, 150, 88);
        repeat (13) @(posedge sys_clk);
        #5 sys_rst_n = 1'b0;
        #1 check("async_reset_clear", out_vec(), 24'd0);
        repeat (3) @(posedge sys_clk);
        #5 sys_rst_n = 1'b1;
        exp_q.push_back(exp_t'{ref_bcd(777777), cyc + 44, 777777});
        repeat (20) @(negedge sys_clk);
        check("post_reset_still_zero", out_vec(), 24'd0);
        repeat (80) @(negedge sys_clk);

        // Drain remaining expectations with a bound.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 200) begin
            @(negedge sys_clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
